tag_bank_fill_ctrl: RTL and testbench

- Write-side counterpart of the 4-way tag-bank read mux in the cache tag path.
- On a miss refill, chooses a victim way per set (first invalid way, else tree pseudo-LRU) and drives one-hot write enables, set index, tag and valid bit into the four tag banks.
- Tracks hits to keep PLRU state current; supports a full invalidate (flush) sweep across all sets.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/tag_plru_tree.sv | 24 ++
 rtl/tag_bank_fill_ctrl.sv | 131 +++++++++++++
 tb/tb_tag_bank_fill_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the 4-way cache tag path.
package cache_pkg;

  localparam int unsigned WAYS   = 4;
  localparam int unsigned PLRU_W = 3;

  typedef logic [1:0]        way_t;
  typedef logic [PLRU_W-1:0] plru_t;

  typedef enum logic [2:0] {IDLE, VICTIM, WRITE, DONE, FLUSH} fill_state_t;

  // Tree-PLRU touch: flip the bits on the path so they point away from way w.
  function automatic plru_t plru_touch(plru_t p, way_t w);
    plru_t r;
    r    = p;
    r[0] = ~w[1];
    if (!w[1]) r[1] = (w == 2'd0);
    else       r[2] = (w == 2'd2);
    return r;
  endfunction

endpackage

// File: rtl/tag_plru_tree.sv
// Victim selection (first invalid way, else tree PLRU) and PLRU touch update for one set.
module tag_plru_tree
  import cache_pkg::*;
(
  input  plru_t            plru,
  input  logic [WAYS-1:0]  valid,
  input  way_t             way,
  output way_t             victim,
  output plru_t            plru_next
);

  always_comb begin
    victim = 2'd0;
    if      (!valid[0]) victim = 2'd0;
    else if (!valid[1]) victim = 2'd1;
    else if (!valid[2]) victim = 2'd2;
    else if (!valid[3]) victim = 2'd3;
    else if (!plru[0])  victim = plru[1] ? 2'd1 : 2'd0;
    else                victim = plru[2] ? 2'd3 : 2'd2;
  end

  assign plru_next = plru_touch(plru, way);

endmodule

// File: rtl/tag_bank_fill_ctrl.sv
// Refill/flush write controller for the four tag banks: victim choice, bank writes,
// PLRU tracking on hits and fills, and a full invalidate sweep.
module tag_bank_fill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned TAG_W    = 20,
  parameter int unsigned SET_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hit_valid,
  input  logic [SET_BITS-1:0] hit_set,
  input  logic [1:0]          hit_way,
  input  logic                fill_req_valid,
  output logic                fill_req_ready,
  input  logic [SET_BITS-1:0] fill_set,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic                flush_req,
  output logic [3:0]          we,
  output logic [SET_BITS-1:0] wr_set,
  output logic [TAG_W-1:0]    wr_tag,
  output logic                wr_valid_bit,
  output logic                fill_done,
  output logic [1:0]          fill_way,
  output logic                flush_done
);

  localparam int unsigned SETS = 2 ** SET_BITS;

  fill_state_t                    state_q;
  logic [SET_BITS-1:0]            set_q;
  logic [TAG_W-1:0]               tag_q;
  way_t                           way_q;
  logic [SET_BITS:0]              cnt_q;
  logic [SETS-1:0][WAYS-1:0]      valid_q;
  plru_t [SETS-1:0]               plru_q;

  way_t  victim;
  plru_t fill_plru;
  plru_t hit_plru;

  tag_plru_tree u_tree (
    .plru      (plru_q[set_q]),
    .valid     (valid_q[set_q]),
    .way       (way_q),
    .victim    (victim),
    .plru_next (fill_plru)
  );

  assign hit_plru       = plru_touch(plru_q[hit_set], hit_way);
  assign fill_req_ready = (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      set_q        <= '0;
      tag_q        <= '0;
      way_q        <= '0;
      cnt_q        <= '0;
      valid_q      <= '0;
      plru_q       <= '0;
      we           <= '0;
      wr_set       <= '0;
      wr_tag       <= '0;
      wr_valid_bit <= 1'b0;
      fill_done    <= 1'b0;
      fill_way     <= '0;
      flush_done   <= 1'b0;
    end else begin
      // A hit colliding with the fill write on the same set loses to the fill touch.
      if (hit_valid && (state_q != FLUSH) && !((state_q == WRITE) && (hit_set == set_q))) begin
        plru_q[hit_set] <= hit_plru;
      end
      unique case (state_q)
        IDLE: begin
          if (flush_req) begin
            state_q      <= FLUSH;
            cnt_q        <= '0;
            we           <= 4'b1111;
            wr_set       <= '0;
            wr_tag       <= '0;
            wr_valid_bit <= 1'b0;
          end else if (fill_req_valid) begin
            set_q   <= fill_set;
            tag_q   <= fill_tag;
            state_q <= VICTIM;
          end
        end
        VICTIM: begin
          way_q        <= victim;
          we           <= 4'b0001 << victim;
          wr_set       <= set_q;
          wr_tag       <= tag_q;
          wr_valid_bit <= 1'b1;
          state_q      <= WRITE;
        end
        WRITE: begin
          valid_q[set_q][way_q] <= 1'b1;
          plru_q[set_q]         <= fill_plru;
          we                    <= '0;
          fill_done             <= 1'b1;
          fill_way              <= way_q;
          state_q               <= DONE;
        end
        DONE: begin
          fill_done <= 1'b0;
          state_q   <= IDLE;
        end
        FLUSH: begin
          // cnt_q[SET_BITS] marks the extra flush_done cycle after the last set.
          if (!cnt_q[SET_BITS]) begin
            valid_q[cnt_q[SET_BITS-1:0]] <= '0;
            plru_q[cnt_q[SET_BITS-1:0]]  <= '0;
            cnt_q                        <= cnt_q + 1'b1;
            if (cnt_q[SET_BITS-1:0] == {SET_BITS{1'b1}}) begin
              we         <= '0;
              flush_done <= 1'b1;
            end else begin
              wr_set <= cnt_q[SET_BITS-1:0] + 1'b1;
            end
          end else begin
            flush_done <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_bank_fill_ctrl.sv
// Directed bench for tag_bank_fill_ctrl: fills, PLRU victim order, hit/fill collision,
// flush sweep and asynchronous reset during a write.
module tb_tag_bank_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hit_valid = 1'b0;
  logic [3:0]  hit_set = '0;
  logic [1:0]  hit_way = '0;
  logic        fill_req_valid = 1'b0;
  logic        fill_req_ready;
  logic [3:0]  fill_set = '0;
  logic [19:0] fill_tag = '0;
  logic        flush_req = 1'b0;
  logic [3:0]  we;
  logic [3:0]  wr_set;
  logic [19:0] wr_tag;
  logic        wr_valid_bit;
  logic        fill_done;
  logic [1:0]  fill_way;
  logic        flush_done;

  int total = 0;
  int passes = 0;

  tag_bank_fill_ctrl #(
    .TAG_W    (20),
    .SET_BITS (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hit_valid      (hit_valid),
    .hit_set        (hit_set),
    .hit_way        (hit_way),
    .fill_req_valid (fill_req_valid),
    .fill_req_ready (fill_req_ready),
    .fill_set       (fill_set),
    .fill_tag       (fill_tag),
    .flush_req      (flush_req),
    .we             (we),
    .wr_set         (wr_set),
    .wr_tag         (wr_tag),
    .wr_valid_bit   (wr_valid_bit),
    .fill_done      (fill_done),
    .fill_way       (fill_way),
    .flush_done     (flush_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
  endtask

  // Starts #1 after a rising edge with the DUT idle; ends #1 after the edge leaving DONE.
  task automatic do_fill(input logic [3:0] s, input logic [19:0] t, input logic [1:0] ew,
                         input bit inj, input logic [3:0] hs, input logic [1:0] hw);
    logic [3:0] exp_we;
    exp_we = 4'b0001 << ew;
    chk("ready_idle", 32'(fill_req_ready), 32'd1);
    fill_req_valid = 1'b1;
    fill_set       = s;
    fill_tag       = t;
    @(posedge clk); #1;
    fill_req_valid = 1'b0;
    chk("we_victim", 32'(we), 32'd0);
    @(posedge clk); #1;
    chk("we_write", 32'(we), 32'(exp_we));
    chk("wr_set", 32'(wr_set), 32'(s));
    chk("wr_tag", 32'(wr_tag), 32'(t));
    chk("wr_valid_bit", 32'(wr_valid_bit), 32'd1);
    if (inj) begin
      hit_valid = 1'b1;
      hit_set   = hs;
      hit_way   = hw;
    end
    @(posedge clk); #1;
    hit_valid = 1'b0;
    chk("fill_done", 32'(fill_done), 32'd1);
    chk("fill_way", 32'(fill_way), 32'(ew));
    chk("we_done", 32'(we), 32'd0);
    @(posedge clk); #1;
    chk("fill_done_low", 32'(fill_done), 32'd0);
  endtask

  task automatic do_hit(input logic [3:0] hs, input logic [1:0] hw);
    hit_valid = 1'b1;
    hit_set   = hs;
    hit_way   = hw;
    @(posedge clk); #1;
    hit_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_fill_done", 32'(fill_done), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_wr_set", 32'(wr_set), 32'd0);
    chk("rst_wr_tag", 32'(wr_tag), 32'd0);
    chk("rst_wr_valid_bit", 32'(wr_valid_bit), 32'd0);
    chk("rst_fill_way", 32'(fill_way), 32'd0);
    chk("rst_ready", 32'(fill_req_ready), 32'd1);

    // First fill into an empty set lands in way 0
    do_fill(4'd3, 20'h0ABCD, 2'd0, 1'b0, 4'd0, 2'd0);

    // Set 5: invalid ways first, then PLRU (0,0,0 -> way 0; then 1,1,0 -> way 2)
    do_fill(4'd5, 20'd1, 2'd0, 1'b0, 4'd0, 2'd0);
    do_fill(4'd5, 20'd2, 2'd1, 1'b0, 4'd0, 2'd0);
    do_fill(4'd5, 20'd3, 2'd2, 1'b0, 4'd0, 2'd0);
    do_fill(4'd5, 20'd4, 2'd3, 1'b0, 4'd0, 2'd0);
    do_fill(4'd5, 20'd5, 2'd0, 1'b0, 4'd0, 2'd0);
    do_fill(4'd5, 20'd6, 2'd2, 1'b0, 4'd0, 2'd0);

    // Hits on way 0 then way 2 leave b0=0,b1=1 -> way 1
    do_hit(4'd5, 2'd0);
    do_hit(4'd5, 2'd2);
    do_fill(4'd5, 20'd7, 2'd1, 1'b0, 4'd0, 2'd0);

    // Set 7: hit on way 1 colliding with the way-3 write is dropped -> next victim way 0
    do_fill(4'd7, 20'h70, 2'd0, 1'b0, 4'd0, 2'd0);
    do_fill(4'd7, 20'h71, 2'd1, 1'b0, 4'd0, 2'd0);
    do_fill(4'd7, 20'h72, 2'd2, 1'b0, 4'd0, 2'd0);
    do_fill(4'd7, 20'h73, 2'd3, 1'b1, 4'd7, 2'd1);
    // Hit on set 5 way 3 during this set-7 write still applies -> set 5 victim way 0
    do_fill(4'd7, 20'h74, 2'd0, 1'b1, 4'd5, 2'd3);
    do_fill(4'd5, 20'd8, 2'd0, 1'b0, 4'd0, 2'd0);

    // Flush wins over a simultaneous fill request
    flush_req      = 1'b1;
    fill_req_valid = 1'b1;
    fill_set       = 4'd9;
    @(posedge clk); #1;
    flush_req      = 1'b0;
    fill_req_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("flush_we", 32'(we), 32'hF);
      chk("flush_wr_set", 32'(wr_set), 32'(i));
      chk("flush_wr_tag", 32'(wr_tag), 32'd0);
      chk("flush_vbit", 32'(wr_valid_bit), 32'd0);
      chk("flush_ready", 32'(fill_req_ready), 32'd0);
      chk("flush_done_early", 32'(flush_done), 32'd0);
      @(posedge clk); #1;
    end
    chk("flush_done", 32'(flush_done), 32'd1);
    chk("flush_done_we", 32'(we), 32'd0);
    chk("flush_done_ready", 32'(fill_req_ready), 32'd0);
    @(posedge clk); #1;
    chk("flush_done_low", 32'(flush_done), 32'd0);
    chk("post_flush_ready", 32'(fill_req_ready), 32'd1);
    do_fill(4'd5, 20'h55, 2'd0, 1'b0, 4'd0, 2'd0);
    do_fill(4'd7, 20'h77, 2'd0, 1'b0, 4'd0, 2'd0);

    // Asynchronous reset during WRITE kills the write and the pending fill_done
    fill_req_valid = 1'b1;
    fill_set       = 4'd5;
    fill_tag       = 20'h99;
    @(posedge clk); #1;
    fill_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_we", 32'(we), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(we), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("no_fill_done_1", 32'(fill_done), 32'd0);
    @(posedge clk); #1;
    chk("no_fill_done_2", 32'(fill_done), 32'd0);
    do_fill(4'd5, 20'h9A, 2'd0, 1'b0, 4'd0, 2'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
